// File: rtl/atan2_seq.sv
`default_nettype none
// ============================================================================
// atan2_seq : full-circle arctangent via octant fold, serial divide and LUT.
// Optional ATAN2_ROUND_EN: ratio rounded to nearest, one extra cycle latency.
// Revision  : 1.0
// ============================================================================
module atan2_seq #(
  parameter int INPUT_WIDTH    = 16,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int OUTPUT_WIDTH   = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic signed [INPUT_WIDTH-1:0]  in_i_i,
  input  logic signed [INPUT_WIDTH-1:0]  in_q_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  output logic signed [OUTPUT_WIDTH-1:0] angle_o,
  output logic                           valid_o
);

  localparam int c_aw = INPUT_WIDTH + 1;
  localparam int c_rw = INPUT_WIDTH + 2;
`ifdef ATAN2_ROUND_EN
  localparam int c_qw = LUT_ADDR_WIDTH + 2;
`else
  localparam int c_qw = LUT_ADDR_WIDTH + 1;
`endif
  localparam int c_cw    = $clog2(c_qw + 1);
  localparam int c_lut_n = 2 ** LUT_ADDR_WIDTH;
  localparam logic [LUT_ADDR_WIDTH:0]   c_q_max   = {1'b1, {LUT_ADDR_WIDTH{1'b0}}};
  localparam logic [OUTPUT_WIDTH-1:0]   c_quarter = {2'b01, {(OUTPUT_WIDTH-2){1'b0}}};
  localparam logic [OUTPUT_WIDTH-1:0]   c_half    = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  // Euler series atan(x) = x/(1+x^2) * sum c_n y^n, y = x^2/(1+x^2), in 2^40 fixed point.
  function automatic longint atan_fx(input longint k);
    longint n2, den, t, s;
    n2  = longint'(c_lut_n) * longint'(c_lut_n);
    den = n2 + k * k;
    t   = longint'(1) <<< 40;
    s   = 0;
    for (int n = 0; n < 48; n++) begin
      if (n > 0) t = (((t * k * k) / den) * longint'(2 * n)) / longint'(2 * n + 1);
      s = s + t;
    end
    return (s * k * longint'(c_lut_n)) / den;
  endfunction

  localparam longint c_a1 = atan_fx(longint'(c_lut_n));

  // Scaling against atan(1) keeps the table free of a pi constant.
  function automatic logic [OUTPUT_WIDTH-1:0] lut_val(input longint k);
    longint v;
    v = (atan_fx(k) * (longint'(1) <<< (OUTPUT_WIDTH - 2)) + c_a1) / (longint'(2) * c_a1);
    return v[OUTPUT_WIDTH-1:0];
  endfunction

  logic [OUTPUT_WIDTH-1:0] w_lut [0:c_lut_n];
  for (genvar g = 0; g <= c_lut_n; g++) begin : g_lut
    localparam logic [OUTPUT_WIDTH-1:0] c_val = lut_val(longint'(g));
    assign w_lut[g] = c_val;
  end

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIVIDE, S_LOOKUP, S_MAP} state_t;

  state_t                        r_state;
  logic signed [INPUT_WIDTH-1:0] r_in_i, r_in_q;
  logic                          r_neg_i, r_neg_q, r_swap;
  logic [c_aw-1:0]               r_den;
  logic [c_rw-1:0]               r_rem;
  logic [c_qw-1:0]               r_q;
  logic [c_cw-1:0]               r_cnt;
  logic [OUTPUT_WIDTH-1:0]       r_lut;

  logic [c_aw-1:0]         w_ext_i, w_ext_q, w_mag_i, w_mag_q, w_num, w_den;
  logic                    w_swap, w_ge, w_qbit;
  logic [c_rw-1:0]         w_rem_nxt, w_rem_sh;
  logic [LUT_ADDR_WIDTH:0] w_q_idx;
  logic [OUTPUT_WIDTH-1:0] w_phi0, w_angle;

  assign w_ext_i = {r_in_i[INPUT_WIDTH-1], r_in_i};
  assign w_ext_q = {r_in_q[INPUT_WIDTH-1], r_in_q};
  assign w_mag_i = r_in_i[INPUT_WIDTH-1] ? (~w_ext_i + c_aw'(1)) : w_ext_i;
  assign w_mag_q = r_in_q[INPUT_WIDTH-1] ? (~w_ext_q + c_aw'(1)) : w_ext_q;
  assign w_swap  = w_mag_q > w_mag_i;
  assign w_num   = w_swap ? w_mag_i : w_mag_q;
  assign w_den   = w_swap ? w_mag_q : w_mag_i;

  // Restoring step; a zero divisor always shifts in 0 so (0,0) maps to angle 0.
  assign w_ge      = r_rem >= {1'b0, r_den};
  assign w_qbit    = w_ge && (r_den != '0);
  assign w_rem_nxt = w_ge ? (r_rem - {1'b0, r_den}) : r_rem;
  assign w_rem_sh  = w_rem_nxt << 1;

`ifdef ATAN2_ROUND_EN
  logic [LUT_ADDR_WIDTH:0] w_q_rnd;
  assign w_q_rnd = r_q[c_qw-1:1] + {{LUT_ADDR_WIDTH{1'b0}}, r_q[0]};
  assign w_q_idx = (w_q_rnd > c_q_max) ? c_q_max : w_q_rnd;
`else
  assign w_q_idx = r_q;
`endif

  always_comb begin
    w_phi0  = r_swap ? (c_quarter - r_lut) : r_lut;
    w_angle = w_phi0;
    case ({r_neg_i, r_neg_q})
      2'b10:   w_angle = c_half - w_phi0;
      2'b11:   w_angle = w_phi0 - c_half;
      2'b01:   w_angle = '0 - w_phi0;
      default: w_angle = w_phi0;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_in_i  <= '0;
      r_in_q  <= '0;
      r_neg_i <= 1'b0;
      r_neg_q <= 1'b0;
      r_swap  <= 1'b0;
      r_den   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_lut   <= '0;
      ready_o <= 1'b0;
      angle_o <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ready_o && valid_i) begin
            r_in_i  <= in_i_i;
            r_in_q  <= in_q_i;
            ready_o <= 1'b0;
            r_state <= S_PREP;
          end else begin
            ready_o <= 1'b1;
          end
        end
        S_PREP: begin
          r_neg_i <= r_in_i[INPUT_WIDTH-1];
          r_neg_q <= r_in_q[INPUT_WIDTH-1];
          r_swap  <= w_swap;
          r_rem   <= {1'b0, w_num};
          r_den   <= w_den;
          r_q     <= '0;
          r_cnt   <= '0;
          r_state <= S_DIVIDE;
        end
        S_DIVIDE: begin
          r_rem <= w_rem_sh;
          r_q   <= {r_q[c_qw-2:0], w_qbit};
          r_cnt <= r_cnt + c_cw'(1);
          if (r_cnt == c_cw'(c_qw - 1)) r_state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          r_lut   <= w_lut[w_q_idx];
          r_state <= S_MAP;
        end
        S_MAP: begin
          angle_o <= w_angle;
          valid_o <= 1'b1;
          ready_o <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
